// File: rtl/sbox_step2_sequencer.sv
// Handshake, randomness and clock-gate sequencer around the second masked
// S-box step (two shares): registers the operand in, waits LAT, holds the result.
module sbox_step2_sequencer #(
    parameter bit          low_latency = 1'b0,
    parameter bit          pipeline    = 1'b0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in0,
    input  logic [3:0]  in1,
    input  logic        seed_valid,
    input  logic [15:0] seed,
    output logic [3:0]  st_in0,
    output logic [3:0]  st_in1,
    output logic [3:0]  st_r,
    output logic        gate_en,
    input  logic [3:0]  st_out0,
    input  logic [3:0]  st_out1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out0,
    output logic [3:0]  out1
);
    localparam int         LAT      = low_latency ? 1 : 2;
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  st_in0_q, st_in0_d;
    logic [3:0]  st_in1_q, st_in1_d;
    logic [3:0]  out0_q, out0_d;
    logic [3:0]  out1_q, out1_d;
    logic        lfsr_fb;

    // The pipeline option only has to match the gadget instance; sequencing is identical.
    if (pipeline) begin : g_pipeline_variant
    end else begin : g_flat_variant
    end

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            lfsr_q   <= SEED;
            st_in0_q <= 4'd0;
            st_in1_q <= 4'd0;
            out0_q   <= 4'd0;
            out1_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            st_in0_q <= st_in0_d;
            st_in1_q <= st_in1_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        st_in0_d = st_in0_q;
        st_in1_d = st_in1_q;
        out0_d   = out0_q;
        out1_d   = out1_q;
        case (state_q)
            IDLE: begin
                // A zero seed would lock the LFSR, so it falls back to SEED.
                if (seed_valid) begin
                    lfsr_d = (seed == 16'd0) ? SEED : seed;
                end
                if (in_valid) begin
                    st_in0_d = in0;
                    st_in1_d = in1;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (cnt_q == 2'd0) begin
                    out0_d  = st_out0;
                    out1_d  = st_out1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control outputs decode only the registered state.
    assign in_ready  = (state_q == IDLE);
    assign gate_en   = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign st_in0    = st_in0_q;
    assign st_in1    = st_in1_q;
    assign st_r      = lfsr_q[3:0];
    assign out0      = out0_q;
    assign out1      = out1_q;
endmodule

// File: doc/sbox_step2_sequencer.md
# sbox_step2_sequencer

Control and buffering stage wrapped around the second masked S-box step of the Skinny GHPC/ANF datapath (first-order, two shares). It accepts a 4-bit two-share operand with a valid/ready handshake and registers it onto the step-2 inputs. It drives the step-2 fresh-randomness bus from an internal LFSR and asserts the gadget clock-gate enable only while a transaction is in flight. It then captures the two output shares after the gadget latency and holds them for a valid/ready consumer.

## Interface
- `low_latency`, default 0: must match the step-2 instance. Gadget latency is LAT = 1 if `low_latency`=1, else LAT = 2.
- `pipeline`, default 0: must match the step-2 instance. This block does not change behaviour with it.
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `clk`  in  1: single clock. All registers are on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand valid.
- `in_ready`  out  1: operand accepted when `in_valid`&`in_ready` are both high on a rising edge.
- `in0`, `in1`  in  4 each: input shares 0 and 1.
- `seed_valid`  in  1: load `seed` into the LFSR. Honoured in IDLE only.
- `seed`  in  16: new LFSR state. The value 0 is replaced by `SEED`.
- `st_in0`, `st_in1`  out  4 each: registered shares driven to step-2 `in0`/`in1`.
- `st_r`  out  4: fresh randomness to step-2 `r`. Equals lfsr[3:0].
- `gate_en`  out  1: clock-gate enable for the step-2 gadget registers.
- `st_out0`, `st_out1`  in  4 each: step-2 output shares.
- `out_valid`  out  1: result held.
- `out_ready`  in  1: consumer accepts the result.
- `out0`, `out1`  out  4 each: registered result shares.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On an input handshake: latch `in0`→`st_in0` and `in1`→`st_in1`, load cnt=LAT-1, go to BUSY.
  - If `seed_valid` occurs in the same cycle as the handshake, the seed load wins over LFSR advance. The handshake is still taken.
- BUSY:
  - `in_ready`=0, `gate_en`=1.
  - The LFSR advances every BUSY cycle; cnt decrements.
  - When cnt==0: capture `st_out0`→`out0` and `st_out1`→`out1`, go to DONE.
  - `seed_valid` is ignored.
- DONE:
  - `out_valid`=1, `gate_en`=0, `in_ready`=0.
  - On `out_ready`: go to IDLE and clear `out_valid`.
  - `out0`/`out1` are held stable until the handshake.
- LFSR: 16-bit Fibonacci shift-right.
  - fb = b0^b2^b3^b5 (polynomial x^16+x^14+x^13+x^11+1); next = {fb, lfsr[15:1]}.
  - It never reaches 0.
  - It holds its value outside BUSY, so `st_r` is constant while the gadget is gated.
- Share hygiene:
  - Shares are never XORed together or with each other's registers.
  - Share 0 and share 1 paths use separate registers.
  - `st_in0`/`st_in1` keep the last operand after completion; they are not cleared.
- Reset (asynchronous, any state, including mid-BUSY):
  - state=IDLE, cnt=0, lfsr=`SEED`.
  - `st_in0`=`st_in1`=0, `out0`=`out1`=0.
  - `in_ready`=1, `out_valid`=0, `gate_en`=0.
  - An in-flight transaction is dropped.
- All control outputs are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready` to any output.

## Timing
- Input handshake on edge ending cycle T:
  - `st_in*` valid from cycle T+1.
  - `gate_en`=1 in cycles T+1 … T+LAT.
  - Capture on the edge ending cycle T+LAT.
  - `out_valid`=1 from cycle T+LAT+1.
- Latency, input handshake to `out_valid`: LAT+1 cycles (3 by default, 2 with `low_latency`=1).
- Throughput: one operand per LAT+2 cycles with `out_ready` held high, since DONE→IDLE costs one cycle.
- `st_r` changes exactly once per BUSY cycle, so each gadget clock sees fresh randomness.

## Test plan
- Reset with defaults:
  - `st_r`=4'h1, `in_ready`=1, `out_valid`=0, `gate_en`=0, `out0`=`out1`=0.
- LFSR sequence over two BUSY cycles:
  - `in0`=4'hA, `in1`=4'h3 handshake at T.
  - `st_in0`=A and `st_in1`=3 at T+1.
  - `st_r`=1 at T+1 and 0 at T+2. The LFSR reaches 16'h5670, then 16'hAB38 in DONE, so `st_r`=8 while held.
  - `out_valid` at T+3.
  - `out0`^`out1` equals the unmasked step-2 model output of A^3=4'h9.
- `low_latency`=1:
  - `gate_en` is high for exactly one cycle and `out_valid` rises at T+2.
- Back-pressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid`.
  - `out0`/`out1`, `st_r` stay constant, `gate_en`=0, `in_ready`=0.
  - A new `in_valid` is not accepted.
  - Release → IDLE one cycle later.
- Seed handling:
  - `seed_valid` with seed=0 in IDLE → LFSR=16'hACE1.
  - seed=16'h1234 with `seed_valid` during BUSY → ignored; the sequence continues unchanged.
- Reset asserted mid-BUSY:
  - `gate_en` drops immediately, `out_valid` stays 0, `st_in*`=0, `st_r`=4'h1.
  - After release, a new operand completes normally.
